// File: rtl/access_ctrl_n.sv
// Keypad access controller: gates NUM_CH load strobes behind a NUM_DIGITS-digit passcode.
// Define ACCESS_LOCKOUT_EN to build the brute-force lockout (fail/lock counters, LOCKOUT state).

module access_ctrl_lane (
  input  logic load_in,
  input  logic grant,
  output logic load_out
);
  assign load_out = load_in & grant;
endmodule

module access_ctrl_n #(
  parameter int DIGIT_W    = 4,
  parameter int NUM_DIGITS = 4,
  parameter logic [DIGIT_W*NUM_DIGITS-1:0] PASSCODE = 16'h3153,
  parameter int NUM_CH      = 2,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CH-1:0]  load_in,
  input  logic [DIGIT_W-1:0] passnum,
  input  logic               p_enter,
  output logic [NUM_CH-1:0]  load_out,
  output logic               passr,
  output logic               passg,
  output logic [2:0]         state_acc
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ENTER   = 3'd1;
  localparam logic [2:0] GRANT   = 3'd2;
  localparam logic [2:0] LOCKOUT = 3'd3;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [2:0]         state;
  logic [IDX_W-1:0]   idx;
  logic               err;
  logic               p_en_q;
  logic               press;
  logic               mis;
  logic               last;
  logic               grant;
  logic [2:0]         fail_state;
  logic [DIGIT_W-1:0] digits [NUM_DIGITS];

  // digit 0 lives in the most-significant field of PASSCODE
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    assign digits[k] = PASSCODE[(NUM_DIGITS-1-k)*DIGIT_W +: DIGIT_W];
  end

  assign press = p_enter & ~p_en_q;
  assign mis   = passnum != digits[(state == IDLE) ? IDX_W'(0) : idx];
  assign last  = idx == IDX_W'(NUM_DIGITS-1);

`ifdef ACCESS_LOCKOUT_EN
  localparam int FC_W = $clog2(MAX_FAILS+1);
  localparam int LC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  logic [FC_W-1:0] fail_cnt;
  logic [LC_W-1:0] lock_cnt;
  logic            lock_done;

  assign lock_done  = lock_cnt == LC_W'(LOCK_CYCLES-1);
  assign fail_state = (fail_cnt >= FC_W'(MAX_FAILS-1)) ? LOCKOUT : IDLE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_cnt <= '0;
      lock_cnt <= '0;
    end else begin
      if (state == ENTER && press && last) begin
        if (err | mis) begin
          if (fail_cnt != FC_W'(MAX_FAILS)) fail_cnt <= fail_cnt + FC_W'(1);
        end else begin
          fail_cnt <= '0;
        end
      end
      if (state == LOCKOUT) begin
        if (lock_done) begin
          lock_cnt <= '0;
          fail_cnt <= '0;
        end else begin
          lock_cnt <= lock_cnt + LC_W'(1);
        end
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(MAX_FAILS), 32'(LOCK_CYCLES)};
  assign fail_state = IDLE;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      idx    <= '0;
      err    <= 1'b0;
      p_en_q <= 1'b1;
    end else begin
      p_en_q <= p_enter;
      case (state)
        IDLE: if (press) begin
          err   <= mis;
          idx   <= IDX_W'(1);
          state <= ENTER;
        end
        // every sequence runs to full length so a bad digit's position stays hidden
        ENTER: if (press) begin
          if (last) begin
            idx   <= '0;
            err   <= 1'b0;
            state <= (err | mis) ? fail_state : GRANT;
          end else begin
            idx <= idx + IDX_W'(1);
            err <= err | mis;
          end
        end
        GRANT: if (press) state <= IDLE;
`ifdef ACCESS_LOCKOUT_EN
        LOCKOUT: if (lock_done) state <= IDLE;
`endif
        default: begin
          state <= IDLE;
          idx   <= '0;
          err   <= 1'b0;
        end
      endcase
    end
  end

  assign grant     = state == GRANT;
  assign passg     = grant;
  assign passr     = ~grant;
  assign state_acc = state;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    access_ctrl_lane u_lane (
      .load_in  (load_in[i]),
      .grant    (grant),
      .load_out (load_out[i])
    );
  end
endmodule

// File: tb/tb_access_ctrl_n.sv
// Randomized scoreboard bench for access_ctrl_n against a sequence-level reference model.
module tb_access_ctrl_n;
  localparam int ND = 4;
  localparam int MF = 3;
  localparam int LC = 8;
  localparam logic [15:0] CODE = 16'h3153;
`ifdef ACCESS_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] load_in = 2'b11;
  logic [3:0] passnum = '0;
  logic       p_enter = 1'b0;
  logic [1:0] load_out;
  logic       passr, passg;
  logic [2:0] state_acc;

  always #5 clk = ~clk;

  access_ctrl_n #(
    .DIGIT_W(4), .NUM_DIGITS(ND), .PASSCODE(CODE), .NUM_CH(2),
    .MAX_FAILS(MF), .LOCK_CYCLES(LC)
  ) dut (
    .clk(clk), .rst(rst), .load_in(load_in), .passnum(passnum),
    .p_enter(p_enter), .load_out(load_out), .passr(passr),
    .passg(passg), .state_acc(state_acc)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] ex);
    n_cmp++;
    if (act !== ex) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, ex, $time);
    end
  endtask

  // Reference model: collects digits, judges the whole sequence at once
  int  code_d[ND] = '{3, 1, 5, 3};
  int  m_st = 0, m_fails = 0, m_lock = 0;
  bit  m_prev = 1'b1;
  int  m_buf[$];

  always @(posedge clk) begin
    bit pr, ok;
    if (!rst) begin
      m_st = 0; m_fails = 0; m_lock = 0; m_prev = 1'b1; m_buf.delete();
    end else begin
      pr = p_enter && !m_prev;
      m_prev = p_enter;
      case (m_st)
        0: if (pr) begin m_buf.delete(); m_buf.push_back(int'(passnum)); m_st = 1; end
        1: if (pr) begin
          m_buf.push_back(int'(passnum));
          if (m_buf.size() == ND) begin
            ok = 1'b1;
            foreach (m_buf[k]) if (m_buf[k] != code_d[k]) ok = 1'b0;
            m_buf.delete();
            if (ok) begin
              m_st = 2; m_fails = 0;
            end else begin
              m_fails++;
              if (LOCK_EN && m_fails >= MF) begin m_st = 3; m_lock = LC; end
              else m_st = 0;
            end
          end
        end
        2: if (pr) m_st = 0;
        default: begin
          m_lock--;
          if (m_lock == 0) begin m_st = 0; m_fails = 0; end
        end
      endcase
    end
    exp_q.push_back(m_st);
  end

  // Monitor: one expectation per cycle, checked mid-cycle
  always @(negedge clk) begin
    int e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state_acc", 32'(state_acc), 32'(e));
      chk("passg", 32'(passg), 32'(e == 2));
      chk("passr", 32'(passr), 32'(e != 2));
      chk("load_out", 32'(load_out), (e == 2) ? 32'(load_in) : 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    load_in = 2'($urandom);
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic press(int d, int hold);
    passnum = 4'(d);
    p_enter = 1'b1;
    repeat (hold) step();
    p_enter = 1'b0;
    passnum = 4'($urandom);
    step();
  endtask

  task automatic enter_code(logic [15:0] c, int maxhold);
    for (int k = 0; k < ND; k++)
      press(int'(c[15-4*k -: 4]), int'($urandom_range(1, maxhold)));
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_state"}, 32'(state_acc), 32'd0);
    chk({tag, "_passg"}, 32'(passg), 32'd0);
    chk({tag, "_passr"}, 32'(passr), 32'd1);
    chk({tag, "_load"}, 32'(load_out), 32'd0);
  endtask

  // Asserted mid-cycle so access must drop without any clock edge
  task automatic do_reset(bit hold_btn);
    @(negedge clk);
    #1;
    load_in = 2'b11;
    p_enter = hold_btn;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    step();
    if (hold_btn) begin
      idle(3);
      p_enter = 1'b0;
      step();
    end
  endtask

  initial begin : main
    logic [15:0] c;
    #1;
    check_reset_outputs("por");
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    step();

    enter_code(16'h3453, 1); idle(3);          // wrong code
    enter_code(CODE, 1);     idle(4);          // grant
    press(int'($urandom_range(0, 15)), 1); idle(2); // logout
    enter_code(CODE, 1);     idle(2);
    do_reset(1'b0);                            // reset in GRANT
    enter_code(CODE, 2);     idle(2);
    press(3, 1); press(1, 1);
    do_reset(1'b0);                            // reset after two digits
    enter_code(CODE, 1);     idle(2);
    press(9, 1);
    press(3, 5); press(1, 1); press(5, 2); press(3, 1); idle(2); // held press
    do_reset(1'b1);                            // button held through reset
    enter_code(CODE, 1);     idle(2);
    press(0, 1);

    repeat (3) begin enter_code(16'h1234, 1); idle(1); end   // lockout entry
    enter_code(CODE, 1);     idle(10);
    enter_code(CODE, 1);     idle(2);
    press(7, 1);

    for (int i = 0; i < 60; i++) begin
      c = ($urandom_range(0, 2) == 0) ? CODE : 16'($urandom);
      if ($urandom_range(0, 3) == 0) c[4*$urandom_range(0, 3) +: 4] = 4'($urandom);
      enter_code(c, 3);
      idle(int'($urandom_range(0, 4)));
      if ($urandom_range(0, 3) == 0) idle(10);
      if ($urandom_range(0, 2) == 0) press(int'($urandom_range(0, 15)), int'($urandom_range(1, 2)));
      if ($urandom_range(0, 11) == 0) do_reset(1'($urandom));
    end

    idle(3);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/access_ctrl_n.md
# access_ctrl_n

Parametrised keypad access controller that gates NUM_CH load strobes behind a NUM_DIGITS-digit passcode entered one digit per press. It sits between the debounced keypad/button front end and the player-load logic. It generalises the fixed 4-digit, 2-channel access FSM with configurable digit width, digit count and channel count, whole-sequence (non-revealing) checking, explicit logout, and optional brute-force lockout.

## Interface
Parameters:
- DIGIT_W, 4, bits per passcode digit
- NUM_DIGITS, 4, digits per sequence (≥2)
- PASSCODE, 16'h3153, DIGIT_W*NUM_DIGITS bits; digit 0 = most-significant DIGIT_W field
- NUM_CH, 2, number of gated load channels
- MAX_FAILS, 3, consecutive failed sequences before lockout (lockout build only)
- LOCK_CYCLES, 1000, lockout duration in clk cycles (lockout build only)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- load_in  in  NUM_CH  load strobes to be gated
- passnum  in  DIGIT_W  current keypad digit
- p_enter  in  1  enter button, level (debounced upstream)
- load_out  out  NUM_CH  gated load strobes
- passr  out  1  red indicator: access denied
- passg  out  1  green indicator: access granted
- state_acc  out  3  current FSM state code

## Operation
- Press detect: p_en_q <= p_enter each cycle; press = p_enter & ~p_en_q. p_en_q resets to 1, so a button held through reset is not a press.
- States (state_acc): IDLE=0, ENTER=1, GRANT=2, LOCKOUT=3; codes 4–7 unused, recover to IDLE.
- IDLE: on press, compare passnum to digit 0; err <= mismatch; idx <= 1; go to ENTER.
- ENTER: on press, compare passnum to digit[idx]; err accumulates (OR). The sequence always runs to NUM_DIGITS presses, so mismatch position is never revealed.
  - On the last press (idx = NUM_DIGITS-1): with no error, go to GRANT and clear fail_cnt. With an error, go to IDLE, fail_cnt++.
  - idx, err clear on every exit.
- GRANT: any press = logout, go to IDLE. passnum is ignored.
- LOCKOUT: presses ignored; lock_cnt counts up each cycle. At lock_cnt = LOCK_CYCLES-1, go to IDLE and clear fail_cnt and lock_cnt.
- Outputs:
  - passg = (state==GRANT); passr = ~passg (registered state, no decode glitches).
  - load_out[i] = load_in[i] & passg; combinational from load_in, so a strobe passes in the same cycle.
- Widths:
  - idx: $clog2(NUM_DIGITS)
  - fail_cnt: $clog2(MAX_FAILS+1), saturating
  - lock_cnt: $clog2(LOCK_CYCLES)

## Timing
- Reset (rst=0, asynchronous): state=IDLE, idx=0, err=0, fail_cnt=0, lock_cnt=0, p_en_q=1. Outputs: load_out=0, passg=0, passr=1, state_acc=0.
  - Assertion mid-sequence or in GRANT drops access immediately, without waiting for a clock.
- Press latency: the press is registered on the first rising edge where p_enter=1 and p_en_q=0. The state change is visible 1 cycle after that edge.
  - passg rises the cycle after the edge that samples the last correct digit.
- A p_enter held high for N cycles counts as one press. It must return low for ≥1 sampled cycle before the next press.
- passnum must be stable at the press edge; its value in other cycles is don't-care.
- Lockout entry: same edge as the MAX_FAILS-th failed last digit. Exit to IDLE occurs exactly LOCK_CYCLES cycles later.
  - A press on the exit edge is ignored, because the FSM is still in LOCKOUT at that edge.
- A success resets fail_cnt; failures need not be consecutive with respect to logout, but any success clears the count.

## Configuration
- ACCESS_LOCKOUT_EN defined: fail_cnt, lock_cnt and the LOCKOUT state are built. After MAX_FAILS failed sequences the FSM goes to LOCKOUT.
- Undefined: no fail or lock counters are built. A failed sequence always returns to IDLE, state_acc never equals 3, and MAX_FAILS/LOCK_CYCLES are unused.

## Test plan
- Wrong code 3,4,5,3 (one-cycle presses, load_in=2'b11): state_acc goes 1 after the first press, back to 0 after the fourth. passr=1 and load_out=2'b00 throughout.
- Correct code 3,1,5,3: passg=1 and state_acc=2 the cycle after the fourth press edge. load_out follows load_in (toggle load_in=01/10 → identical load_out).
- Logout: a press in GRANT gives state_acc=0 and load_out=0 on the next cycle. Re-entering 3,1,5,3 re-grants.
- Held p_enter: digit 3 with p_enter high for 5 cycles advances idx once only. Holding p_enter through reset release produces no press.
- Lockout (ACCESS_LOCKOUT_EN, LOCK_CYCLES=8):
  - Three wrong sequences give state_acc=3; a correct sequence entered during lockout is ignored.
  - Exactly 8 cycles after entry, state_acc=0, and 3,1,5,3 then grants.
- Reset mid-operation: rst=0 asserted in GRANT and again after 2 digits. Immediately load_out=0, passr=1, state_acc=0, and the next sequence starts from digit 0.
